// File: rtl/vr_pkg.sv
// Shared defaults and FSM state encoding for the two-requester memory arbiter.
package vr_pkg;

  localparam int unsigned AwDefault = 5;
  localparam int unsigned DwDefault = 8;

  typedef enum logic [2:0] {
    StIdle,
    StBusy0,
    StBusy1,
    StDone0,
    StDone1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled with arbiter/driver views.
interface mem_arbiter_if import vr_pkg::*; #(
  parameter int unsigned AW = AwDefault,
  parameter int unsigned DW = DwDefault
);

  logic          req0;
  logic          wen0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;

  logic          req1;
  logic          wen1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;

  logic [DW-1:0] rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  // Arbiter side.
  modport slave (
    input  req0, wen0, addr0, wdata0,
    input  req1, wen1, addr1, wdata1,
    input  mem_rdata,
    output ack0, ack1, rdata, busy,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester / memory model side.
  modport master (
    output req0, wen0, addr0, wdata0,
    output req1, wen1, addr1, wdata1,
    output mem_rdata,
    input  ack0, ack1, rdata, busy,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: on contention the requester not granted last wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_idx
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = 1'b0;
    if (req0 && req1) begin
      gnt_idx = ~last_gnt;
    end else begin
      gnt_idx = req1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: IDLE -> BUSYn (memory access) -> DONEn (ack).
module mem_arbiter import vr_pkg::*; #(
  parameter int unsigned AW = AwDefault,
  parameter int unsigned DW = DwDefault
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  arb_state_e    state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          gnt_valid;
  logic          gnt_idx;
  logic          en;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack0;
  logic          ack1;
  logic          rd_bypass;

  rr_arb2 u_rr_arb2 (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .last_gnt  (last_gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    rdata_d    = rdata_q;
    en         = 1'b0;
    we         = 1'b0;
    addr       = '0;
    wdata      = '0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    rd_bypass  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          state_d    = gnt_idx ? StBusy1 : StBusy0;
          last_gnt_d = gnt_idx;
        end
      end
      StBusy0: begin
        en      = 1'b1;
        we      = bus.wen0;
        addr    = bus.addr0;
        wdata   = bus.wdata0;
        state_d = StDone0;
      end
      StBusy1: begin
        en      = 1'b1;
        we      = bus.wen1;
        addr    = bus.addr1;
        wdata   = bus.wdata1;
        state_d = StDone1;
      end
      StDone0: begin
        ack0 = 1'b1;
        if (!bus.wen0) begin
          rdata_d   = bus.mem_rdata;
          rd_bypass = 1'b1;
        end
        state_d = StIdle;
      end
      StDone1: begin
        ack1 = 1'b1;
        if (!bus.wen1) begin
          rdata_d   = bus.mem_rdata;
          rd_bypass = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      rdata_q    <= rdata_d;
    end
  end

  // Reset gates every strobe so an access caught by reset never commits or acks.
  assign bus.mem_en    = rst & en;
  assign bus.mem_we    = rst & en & we;
  assign bus.mem_addr  = (rst & en) ? addr : '0;
  assign bus.mem_wdata = (rst & en) ? wdata : '0;
  assign bus.ack0      = rst & ack0;
  assign bus.ack1      = rst & ack1;
  assign bus.busy      = rst & (state_q != StIdle);

  // Read data arrives from memory during DONE; forward it so it is valid alongside ack.
  assign bus.rdata = (rst & rd_bypass) ? bus.mem_rdata : rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle plus literal checks.
module tb_mem_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;

  logic clk;
  logic rst;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous memory: one-cycle read latency, write on enabled edge.
  logic [DW-1:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 7 + 3);
    bus.mem_rdata <= '0;
    forever begin
      @(posedge clk);
      if (bus.mem_en) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        else            bus.mem_rdata <= mem[bus.mem_addr];
      end
    end
  end

  // Transaction-level model: phase 0 idle, 1 memory access, 2 acknowledge.
  int            m_phase = 0;
  int            m_owner = 0;
  int            m_last  = 1;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] ref_mem [32];
  bit            m_valid = 1'b0;

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 7 + 3);
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_phase = 0;
        m_last  = 1;
        m_rdata = '0;
      end else if (m_phase == 0) begin
        if (bus.req0 || bus.req1) begin
          if (bus.req0 && bus.req1) m_owner = 1 - m_last;
          else                      m_owner = bus.req1 ? 1 : 0;
          m_last  = m_owner;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (m_owner == 1 && bus.wen1) ref_mem[bus.addr1] = bus.wdata1;
        if (m_owner == 0 && bus.wen0) ref_mem[bus.addr0] = bus.wdata0;
        m_phase = 2;
      end else begin
        if (m_owner == 1 && !bus.wen1) m_rdata = ref_mem[bus.addr1];
        if (m_owner == 0 && !bus.wen0) m_rdata = ref_mem[bus.addr0];
        m_phase = 0;
      end
      m_valid = 1'b1;
    end
  end

  // Per-cycle compare of all outputs against the model.
  logic          o_we;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata;
  logic          e_en;
  logic          e_ack;
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        o_we    = (m_owner == 1) ? bus.wen1 : bus.wen0;
        o_addr  = (m_owner == 1) ? bus.addr1 : bus.addr0;
        o_wdata = (m_owner == 1) ? bus.wdata1 : bus.wdata0;
        e_en    = rst && m_phase == 1;
        e_ack   = rst && m_phase == 2;
        chk("busy", 32'(bus.busy), 32'(rst && m_phase != 0));
        chk("mem_en", 32'(bus.mem_en), 32'(e_en));
        chk("mem_we", 32'(bus.mem_we), 32'(e_en && o_we));
        chk("mem_addr", 32'(bus.mem_addr), e_en ? 32'(o_addr) : 32'd0);
        chk("mem_wdata", 32'(bus.mem_wdata), e_en ? 32'(o_wdata) : 32'd0);
        chk("ack0", 32'(bus.ack0), 32'(e_ack && m_owner == 0));
        chk("ack1", 32'(bus.ack1), 32'(e_ack && m_owner == 1));
        chk("rdata", 32'(bus.rdata),
            (e_ack && !o_we) ? 32'(ref_mem[o_addr]) : 32'(m_rdata));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on requester n; returns negedges from request to ack (-1 on timeout).
  task automatic txn(input int n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     output int lat, output logic [DW-1:0] rd);
    lat = -1;
    rd  = '0;
    if (n == 0) begin
      bus.wen0 = w; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
    end else begin
      bus.wen1 = w; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ((n == 0 && bus.ack0) || (n == 1 && bus.ack1)) begin
        lat = k;
        rd  = bus.rdata;
        break;
      end
    end
    tick();
    if (n == 0) bus.req0 = 1'b0;
    else        bus.req1 = 1'b0;
  endtask

  int            lat;
  logic [DW-1:0] rd;
  int            order[$];
  int            exp_order[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  int            cnt_ack0, cnt_ack1, cnt_en;

  initial begin
    rst = 1'b0;
    bus.req0 = 1'b1; bus.wen0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b1; bus.wen1 = 1'b1; bus.addr1 = '0; bus.wdata1 = '0;

    // Reset held two cycles with both requests high.
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_acks", 32'({bus.ack0, bus.ack1}), 32'd0);
      chk("rst_rdata", 32'(bus.rdata), 32'd0);
    end
    tick();
    bus.req0 = 1'b0; bus.req1 = 1'b0; rst = 1'b1;
    tick();

    // Contention from reset, sustained for 8 transactions.
    bus.wen0 = 1'b0; bus.addr0 = 5'd4;
    bus.wen1 = 1'b1; bus.addr1 = 5'd4; bus.wdata1 = 8'h77;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int k = 0; k < 40 && order.size() < 8; k++) begin
      @(negedge clk);
      if (bus.ack0 && bus.ack1) chk("ack_overlap", 32'd1, 32'd0);
      if (bus.ack0 || bus.ack1) order.push_back(bus.ack1 ? 1 : 0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("contention_txn_count", 32'(order.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < order.size()) chk($sformatf("grant_order[%0d]", i), 32'(order[i]), 32'(exp_order[i]));
    end
    chk("contention_rdata_hold", 32'(bus.rdata), 32'h77);
    tick();

    // Single write then read-back on requester 1.
    txn(1, 1'b1, 5'h1F, 8'hA5, lat, rd);
    chk("wr_latency", 32'(lat), 32'd2);
    txn(1, 1'b0, 5'h1F, 8'h00, lat, rd);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_data_1F", 32'(rd), 32'hA5);

    // Reset during BUSY1 of a write: must not commit or ack.
    bus.wen1 = 1'b1; bus.addr1 = 5'h02; bus.wdata1 = 8'h3C; bus.req1 = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_busy_mem_en", 32'(bus.mem_en), 32'd0);
    tick();
    rst = 1'b1; bus.req1 = 1'b0;
    cnt_ack1 = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ack1) cnt_ack1++;
    end
    chk("rst_abort_no_ack1", 32'(cnt_ack1), 32'd0);
    tick();
    txn(1, 1'b0, 5'h02, 8'h00, lat, rd);
    chk("rst_abort_old_data", 32'(rd), 32'h11);

    // req0 pulsed for one cycle during BUSY1 is dropped.
    bus.wen1 = 1'b1; bus.addr1 = 5'h06; bus.wdata1 = 8'h42; bus.req1 = 1'b1;
    tick();
    bus.wen0 = 1'b0; bus.addr0 = 5'h06; bus.req0 = 1'b1;
    tick();
    bus.req0 = 1'b0;
    cnt_ack0 = 0; cnt_ack1 = 0; cnt_en = 0;
    @(negedge clk);
    if (bus.ack0) cnt_ack0++;
    if (bus.ack1) cnt_ack1++;
    if (bus.mem_en) cnt_en++;
    tick();
    bus.req1 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.ack0) cnt_ack0++;
      if (bus.ack1) cnt_ack1++;
      if (bus.mem_en) cnt_en++;
    end
    chk("withdrawn_no_ack0", 32'(cnt_ack0), 32'd0);
    chk("withdrawn_ack1_once", 32'(cnt_ack1), 32'd1);
    chk("withdrawn_no_access", 32'(cnt_en), 32'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 5, memory address width.
REQ-002 Parameter DW, default 8, memory data width.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
REQ-004 The block SHALL provide these ports for each requester n in {0,1}; requester 0 is the sequence controller, requester 1 is the loader/debug port:
- reqn    in   1   transaction request.
- wen     in   1   1=write, 0=read.
- addrn   in   AW  address.
- wdatan  in   DW  write data.
- ackn    out  1   one-cycle completion strobe.
REQ-005 The block SHALL provide these shared ports:
- rdata      out  DW  registered read data, valid with ack.
- mem_en     out  1   memory enable.
- mem_we     out  1   memory write enable.
- mem_addr   out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in   DW  synchronous memory read data, valid one cycle after mem_en.
- busy       out  1   high while a transaction is in flight.

Function
REQ-006 The block SHALL implement an FSM with states IDLE, BUSY0, BUSY1, DONE0 and DONE1.
REQ-007 In IDLE, if no req is high, the FSM SHALL stay in IDLE.
REQ-008 In IDLE, if only reqn is high, the FSM SHALL go to BUSYn on the next edge.
REQ-009 In IDLE, if both reqs are high, the FSM SHALL grant the requester not recorded in last_gnt and SHALL then set last_gnt to the granted index.
REQ-010 In BUSYn, the block SHALL drive mem_en=1, mem_we=wen, mem_addr=addrn and mem_wdata=wdatan; the FSM SHALL go unconditionally to DONEn.
REQ-011 In DONEn, the block SHALL pulse ackn=1 for exactly one cycle, SHALL load rdata from mem_rdata on read transactions (rdata holds its value on writes), and the FSM SHALL go to IDLE.
REQ-012 Latency: a req first sampled high at edge E SHALL see ack asserted in the cycle after edge E+1, giving 3 cycles per transaction including the IDLE cycle.
REQ-013 Requesters SHALL hold req, we, addr and wdata stable until ack; the arbiter registers none of these and samples them only in BUSYn.
REQ-014 A req still high in the IDLE cycle after its ack SHALL be treated as a new transaction.
REQ-015 The block SHALL never assert ack0 and ack1 in the same cycle, and SHALL never assert ack without a preceding BUSY cycle for the same requester.
REQ-016 A req deasserted before grant SHALL be dropped with no memory access and no ack.
REQ-017 A requester issuing back-to-back transactions while the other requester is continuously requesting SHALL be granted on alternate transactions, with no starvation.
REQ-018 busy SHALL be 1 in BUSY0, BUSY1, DONE0 and DONE1, and 0 in IDLE.
REQ-019 When mem_en=0, mem_addr and mem_wdata SHALL be 0.

Reset
REQ-020 While rst=0 at a posedge, the FSM SHALL go to IDLE, last_gnt SHALL be set to 1, and rdata SHALL be set to 0.
REQ-021 During any cycle with rst=0, the outputs ack0, ack1, mem_en, mem_we, mem_addr, mem_wdata and busy SHALL all be 0.
REQ-022 mem_en and mem_we SHALL be gated by rst, so that a write in BUSY during a reset cycle does not commit.
REQ-023 A transaction interrupted by reset SHALL receive no ack; the requester reissues it after reset.

Structure
REQ-024 A shared package vr_pkg SHALL hold the AW/DW defaults (5/8) and the FSM state encoding typedef.
REQ-025 One sub-module, rr_arb2, SHALL implement the 2-way round-robin pick combinationally from req0, req1 and last_gnt, producing gnt_valid and gnt_idx.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Reset: rst=0 for 2 cycles with req0=req1=1 -> all outputs 0, no mem_en.
- Single write then read: req1 writes addr=5'h1F, wdata=8'hA5, ack1 3 cycles later; req1 then reads 5'h1F -> rdata=8'hA5 coincident with ack1.
- Contention after reset: req0 and req1 rise together -> requester 0 granted first; requester 1 granted next; acks on alternate transactions, never simultaneous.
- Sustained contention: both requests held high for 8 transactions -> grant order 0,1,0,1,0,1,0,1.
- Reset mid-operation: rst=0 during BUSY1 of a write of 8'h3C to addr 5'h02 -> no ack1, mem_we=0, a later read of 5'h02 returns the old value.
- Withdrawn request: req0 pulsed for one cycle while the FSM is in BUSY1 -> no access and no ack0 for requester 0.
